wload_ctrl: RTL and testbench
=============================

Name: wload_ctrl

Overview:
Weight/bias load sequencer for the filter core array. It accepts the AXI-Stream weight words arriving on the source interface while a weight or bias write is active. It generates the per-filter core select (kn), the weight address (wa) and the write strobe, and signals completion. It sits between the register block (wwrite/bwrite/ks/od) and the tiny_dnn_core instances, replacing ad-hoc kn/wa generation in the sample controller.

Parameters:
F_NUM, 16, number of filter cores; kn range 0..F_NUM-1
KN_W, 4, width of kn/od
WA_W, 10, width of wa/ks

Ports:
clk  in  1  system clock (AXIS clock domain)
reset  in  1  synchronous, active-high reset
wwrite  in  1  level; weight-load mode request from register block
bwrite  in  1  level; bias-load mode request from register block
ks  in  WA_W  last weight address per filter (word count minus 1)
od  in  KN_W  last filter index (filter count minus 1)
src_valid  in  1  stream word valid
src_last  in  1  stream last flag
src_ready  out  1  stream ready
kn  out  KN_W  target filter core index
wa  out  WA_W  weight address within the core
wr_en  out  1  write strobe to core kn at address wa
busy  out  1  load in progress
done  out  1  one-cycle pulse on normal or early completion
err  out  1  sticky framing error, cleared at next load start

Behaviour:
- Reset (synchronous, highest priority): state=IDLE; kn=0, wa=0, src_ready=0, wr_en=0, busy=0, done=0, err=0; edge-detect registers cleared. Reset mid-load discards the load with no done pulse.
- Start edges: ww_rise = wwrite & ~wwrite_q; bw_rise = bwrite & ~bwrite_q, where the _q registers update every cycle.
- Shadow capture: ks and od are captured into shadow registers at start. Register changes during a load are ignored.
- States: IDLE, WLOAD, BLOAD, DONE.
- IDLE:
  - ww_rise: go to WLOAD.
  - Else bw_rise: go to BLOAD.
  - Both in the same cycle: WLOAD wins and bw_rise is discarded.
  - On entry to either load state: kn=0, wa=0, err=0.
- Beat definition: beat = src_valid & src_ready.
- src_ready: equals 1 in WLOAD/BLOAD (registered, asserted the cycle after start). 0 in IDLE/DONE.
- wr_en: wr_en = beat, combinational, with the current kn/wa. The core writes on the same edge the beat is accepted.
- busy: 1 in WLOAD, BLOAD and DONE.
- WLOAD, per beat:
  - If wa==ks_s: wa=0. Then if kn==od_s, go to DONE; else kn=kn+1.
  - Else wa=wa+1.
- BLOAD, per beat:
  - wa stays 0.
  - If kn==od_s, go to DONE; else kn=kn+1.
- Final beat framing:
  - The final beat (transition to DONE) must carry src_last=1; otherwise set err=1. The transition still happens.
  - src_last=1 on a non-final beat sets err=1 and forces DONE (early termination). kn/wa freeze.
- Abort: if the active mode bit (wwrite in WLOAD, bwrite in BLOAD) deasserts during a load, go to IDLE next cycle. No done pulse; kn=0, wa=0; a beat in that cycle is still written.
- DONE: done=1 for exactly one cycle, src_ready=0, then go to IDLE. kn/wa hold their final values until the next start.
- No restart while the mode bit stays high: a new load requires deassert then reassert.
- Widths and wrap:
  - kn never exceeds od_s.
  - od_s >= F_NUM is clamped to F_NUM-1 at capture.
  - ks_s=0 means one word per filter.
- Throughput: one word per cycle with src_valid held high. Back-pressure is only via src_valid gaps; counters hold when no beat occurs.

Test Plan:
- WLOAD normal, ks=2, od=1, 6 contiguous beats, src_last on the 6th:
  - wr_en kn/wa sequence (0,0)(0,1)(0,2)(1,0)(1,1)(1,2).
  - done pulses 1 cycle after the 6th beat; err=0.
- BLOAD, od=15, 16 beats with src_valid toggling every other cycle:
  - kn steps 0..15 only on beats; wa=0 throughout.
  - done after beat 16; no writes during invalid cycles.
- Framing errors, ks=3, od=0:
  - src_last on beat 2: DONE after beat 2, err=1, kn=0, wa=1 held.
  - Separately, no src_last on beat 4: done pulses with err=1.
- Abort: wwrite drops after 3 beats (ks=9, od=3):
  - IDLE next cycle, no done, kn=0, wa=0.
  - Reasserting wwrite restarts from (0,0) with err cleared.
- Simultaneous ww_rise and bw_rise: WLOAD chosen. Holding wwrite high after done gives no second load; ks changed mid-load has no effect on the wrap point.
- Synchronous reset asserted mid-WLOAD (kn=2, wa=5): next cycle all outputs 0, state IDLE, no done pulse.

Source files
------------

// File: rtl/wload_ctrl.sv
// Weight/bias load sequencer: steps kn/wa over the filter cores as stream words arrive, strobes writes.
// Latency: src_ready rises the cycle after a start edge; wr_en is combinational with the accepted beat.
// Backpressure: src_ready is held high for the whole load; the source throttles only by gapping src_valid.
module wload_ctrl #(
    parameter int F_NUM = 16,
    parameter int KN_W  = 4,
    parameter int WA_W  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wwrite,
    input  logic            bwrite,
    input  logic [WA_W-1:0] ks,
    input  logic [KN_W-1:0] od,
    input  logic            src_valid,
    input  logic            src_last,
    output logic            src_ready,
    output logic [KN_W-1:0] kn,
    output logic [WA_W-1:0] wa,
    output logic            wr_en,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {IDLE, WLOAD, BLOAD, DONE} state_t;

    localparam logic [KN_W:0] OD_MAX = (KN_W+1)'(F_NUM - 1);

    state_t          state_q, state_d;
    logic [KN_W-1:0] kn_q, kn_d;
    logic [WA_W-1:0] wa_q, wa_d;
    logic [KN_W-1:0] od_s_q, od_s_d;
    logic [WA_W-1:0] ks_s_q, ks_s_d;
    logic            err_q, err_d;
    logic            wwrite_q, bwrite_q;
    logic            ww_rise, bw_rise, beat, mode_on, wa_wrap, kn_last;

    assign ww_rise   = wwrite & ~wwrite_q;
    assign bw_rise   = bwrite & ~bwrite_q;
    assign src_ready = (state_q == WLOAD) || (state_q == BLOAD);
    assign beat      = src_valid & src_ready;
    assign mode_on   = (state_q == WLOAD) ? wwrite : bwrite;
    // Bias loads use one word per filter, so every beat wraps the address.
    assign wa_wrap   = (state_q == BLOAD) || (wa_q == ks_s_q);
    assign kn_last   = (kn_q == od_s_q);

    assign wr_en = beat;
    assign kn    = kn_q;
    assign wa    = wa_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign err   = err_q;

    always_comb begin
        state_d = state_q;
        kn_d    = kn_q;
        wa_d    = wa_q;
        od_s_d  = od_s_q;
        ks_s_d  = ks_s_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (ww_rise || bw_rise) begin
                    state_d = ww_rise ? WLOAD : BLOAD;
                    kn_d    = '0;
                    wa_d    = '0;
                    err_d   = 1'b0;
                    ks_s_d  = ks;
                    od_s_d  = ({1'b0, od} > OD_MAX) ? OD_MAX[KN_W-1:0] : od;
                end
            end
            WLOAD, BLOAD: begin
                if (!mode_on) begin
                    // The beat accepted in this cycle has already been strobed out.
                    state_d = IDLE;
                    kn_d    = '0;
                    wa_d    = '0;
                end else if (beat) begin
                    if (src_last && !(wa_wrap && kn_last)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (wa_wrap) begin
                        wa_d = '0;
                        if (kn_last) begin
                            state_d = DONE;
                            if (!src_last) err_d = 1'b1;
                        end else begin
                            kn_d = kn_q + 1'b1;
                        end
                    end else begin
                        wa_d = wa_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            kn_q     <= '0;
            wa_q     <= '0;
            od_s_q   <= '0;
            ks_s_q   <= '0;
            err_q    <= 1'b0;
            wwrite_q <= 1'b0;
            bwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            kn_q     <= kn_d;
            wa_q     <= wa_d;
            od_s_q   <= od_s_d;
            ks_s_q   <= ks_s_d;
            err_q    <= err_d;
            wwrite_q <= wwrite;
            bwrite_q <= bwrite;
        end
    end

endmodule

// File: tb/tb_wload_ctrl.sv
// Directed bench for wload_ctrl: inputs change and outputs are sampled just after each falling edge.
module tb_wload_ctrl;

    logic       clk;
    logic       reset;
    logic       wwrite, bwrite;
    logic [9:0] ks;
    logic [3:0] od;
    logic       src_valid, src_last, src_ready;
    logic [3:0] kn;
    logic [9:0] wa;
    logic       wr_en, busy, done, err;

    int total = 0;
    int bad   = 0;

    int exp_kn1 [6] = '{0, 0, 0, 1, 1, 1};
    int exp_wa1 [6] = '{0, 1, 2, 0, 1, 2};

    wload_ctrl #(.F_NUM(16), .KN_W(4), .WA_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .wwrite    (wwrite),
        .bwrite    (bwrite),
        .ks        (ks),
        .od        (od),
        .src_valid (src_valid),
        .src_last  (src_last),
        .src_ready (src_ready),
        .kn        (kn),
        .wa        (wa),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic l);
        src_valid = v;
        src_last  = l;
        #1;
    endtask

    initial begin
        reset = 1'b1; wwrite = 1'b0; bwrite = 1'b0; ks = '0; od = '0;
        src_valid = 1'b0; src_last = 1'b0;
        nxt(); nxt();
        reset = 1'b0;
        #1;
        chk("rst_kn", kn, 0);
        chk("rst_wa", wa, 0);
        chk("rst_rdy", src_ready, 0);
        chk("rst_wr", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        // Normal weight load: ks=2, od=1, six contiguous beats.
        nxt(); ks = 10'd2; od = 4'd1; wwrite = 1'b1;
        nxt(); drive(0, 0);
        chk("t1_rdy", src_ready, 1);
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            nxt(); drive(1, i == 5);
            chk("t1_wr", wr_en, 1);
            chk("t1_kn", kn, exp_kn1[i]);
            chk("t1_wa", wa, exp_wa1[i]);
            chk("t1_nodone", done, 0);
        end
        nxt(); drive(0, 0);
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        chk("t1_rdy_done", src_ready, 0);
        chk("t1_kn_fin", kn, 1);
        nxt(); drive(0, 0);
        chk("t1_done_once", done, 0);
        chk("t1_idle", busy, 0);
        nxt(); nxt();
        chk("t1_norestart", busy, 0);
        wwrite = 1'b0;

        // Simultaneous starts pick WLOAD; ks change mid-load is ignored.
        nxt(); ks = 10'd1; od = 4'd0; wwrite = 1'b1; bwrite = 1'b1;
        nxt(); ks = 10'd5; drive(1, 0);
        chk("t2_wr0", wr_en, 1);
        chk("t2_wa0", wa, 0);
        nxt(); drive(1, 1);
        chk("t2_wa1", wa, 1);
        nxt(); drive(0, 0);
        chk("t2_done", done, 1);
        chk("t2_err", err, 0);
        chk("t2_wa_fin", wa, 0);
        nxt(); nxt();
        chk("t2_norestart", busy, 0);
        wwrite = 1'b0; bwrite = 1'b0;

        // Bias load, od=15, valid every other cycle.
        nxt(); od = 4'd15; bwrite = 1'b1;
        nxt();
        for (int i = 0; i < 31; i++) begin
            drive((i % 2) == 0, i == 30);
            chk("t3_wr", wr_en, ((i % 2) == 0) ? 1 : 0);
            chk("t3_kn", kn, (i + 1) / 2);
            chk("t3_wa", wa, 0);
            nxt();
        end
        drive(0, 0);
        chk("t3_done", done, 1);
        chk("t3_kn_fin", kn, 15);
        chk("t3_err", err, 0);

        // Early src_last on beat 2 with ks=3, od=0.
        nxt(); bwrite = 1'b0; ks = 10'd3; od = 4'd0; wwrite = 1'b1;
        nxt(); drive(1, 0);
        chk("t4_wa0", wa, 0);
        nxt(); drive(1, 1);
        chk("t4_wa1", wa, 1);
        nxt(); drive(0, 0);
        chk("t4_done", done, 1);
        chk("t4_err", err, 1);
        chk("t4_kn", kn, 0);
        chk("t4_wa_frz", wa, 1);
        nxt(); drive(0, 0);
        chk("t4_wa_hold", wa, 1);
        chk("t4_err_sticky", err, 1);
        wwrite = 1'b0;
        nxt(); wwrite = 1'b1;
        nxt(); drive(0, 0);
        chk("t4_err_clr", err, 0);
        chk("t4_rdy", src_ready, 1);
        for (int i = 0; i < 4; i++) begin
            nxt(); drive(1, 0);
            chk("t4b_wa", wa, i);
        end
        nxt(); drive(0, 0);
        chk("t4b_done", done, 1);
        chk("t4b_err", err, 1);

        // Abort after three beats, ks=9, od=3.
        wwrite = 1'b0; ks = 10'd9; od = 4'd3;
        nxt(); wwrite = 1'b1;
        nxt();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0);
            chk("t5_wa", wa, i);
            nxt();
        end
        wwrite = 1'b0;
        drive(1, 0);
        chk("t5_abort_wr", wr_en, 1);
        chk("t5_abort_wa", wa, 3);
        nxt(); drive(0, 0);
        chk("t5_idle", busy, 0);
        chk("t5_nodone", done, 0);
        chk("t5_kn", kn, 0);
        chk("t5_wa", wa, 0);
        chk("t5_rdy", src_ready, 0);
        wwrite = 1'b1;
        nxt(); drive(0, 0);
        chk("t5_restart_rdy", src_ready, 1);
        chk("t5_restart_err", err, 0);
        chk("t5_restart_kn", kn, 0);
        chk("t5_restart_wa", wa, 0);

        // Run to kn=2, wa=5, then reset mid-load.
        for (int i = 0; i < 25; i++) begin
            nxt(); drive(1, 0);
            chk("t6_kn", kn, i / 10);
            chk("t6_wa", wa, i % 10);
        end
        nxt(); reset = 1'b1; wwrite = 1'b0; drive(0, 0);
        chk("t6_pre_kn", kn, 2);
        chk("t6_pre_wa", wa, 5);
        nxt(); reset = 1'b0; #1;
        chk("t6_kn", kn, 0);
        chk("t6_wa", wa, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_rdy", src_ready, 0);
        chk("t6_err", err, 0);
        nxt(); #1;
        chk("t6_nodone", done, 0);
        chk("t6_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
